// File: rtl/seq_div_responder.sv
// Multicycle signed restoring divider answering a start/done handshake; quotient on lo, remainder on hi.
// Optional build macro DIV_EARLY_EXIT_EN: skip the iteration phase when |A| < |B|.
module seq_div_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_b_mag, r_q, r_rem, r_hi, r_lo;
  logic             r_sign_a, r_sign_b, r_busy, r_done, r_dzero;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_sub;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge, w_b_zero, w_early, w_last;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_a_mag  = r_sign_a ? (~r_a + 1'b1) : r_a;
    w_b_mag  = r_sign_b ? (~r_b + 1'b1) : r_b;
    w_b_zero = (r_b == '0);
    w_early  = 1'b0;
`ifdef DIV_EARLY_EXIT_EN
    w_early  = (w_a_mag < w_b_mag);
`else
    w_early  = 1'b0;
`endif
    // One extra bit keeps the shifted partial remainder exact before the compare.
    w_rem_sh = {r_rem, r_q[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_b_mag});
    w_sub    = w_rem_sh[WIDTH-1:0] - r_b_mag;
    w_last   = (r_cnt == CW'(WIDTH-1));
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_PREP;
      S_PREP: begin
        if (w_b_zero)     w_next = S_IDLE;
        else if (w_early) w_next = S_FIX;
        else              w_next = S_ITER;
      end
      S_ITER: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_b_mag  <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dzero  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= dividend;
            r_b      <= divisor;
            r_sign_a <= dividend[WIDTH-1];
            r_sign_b <= divisor[WIDTH-1];
            r_dzero  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_PREP: begin
          if (w_b_zero) begin
            r_dzero <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_b_mag <= w_b_mag;
            r_cnt   <= '0;
            if (w_early) begin
              r_q   <= '0;
              r_rem <= w_a_mag;
            end else begin
              r_q   <= w_a_mag;
              r_rem <= '0;
            end
          end
        end
        S_ITER: begin
          r_rem <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          r_lo   <= (r_sign_a ^ r_sign_b) ? (~r_q + 1'b1) : r_q;
          r_hi   <= r_sign_a ? (~r_rem + 1'b1) : r_rem;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign dzero = r_dzero;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
